// File: rtl/des_key_schedule.sv
// DES round-key generator: rotates the latched PC-1 halves per the shift
// schedule and streams PC-2 round keys over a valid/ready handshake.
module des_key_schedule #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] pc1_key,
  input  logic        rkey_ready,
  output logic        rkey_valid,
  output logic [47:0] rkey,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned RK_W   = 48;

  // PC-2 source positions (1-based into CD = {D,C}) for output bits 0..47
  localparam int unsigned PC2_TAB [RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CD_W-1:0]  cd, cd_nxt;
  logic [3:0]       round_nxt;
  logic             mode_dec, mode_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             last_key;

  // Index 0 is DES position 1, so a DES left rotate moves bits toward index 0
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] c,
                                             input logic two);
    return two ? {c[1:0], c[HALF_W-1:2]} : {c[0], c[HALF_W-1:1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] c,
                                             input logic two);
    return two ? {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2]}
               : {c[HALF_W-2:0], c[HALF_W-1]};
  endfunction

  // SH[idx] == 2 for every 1-based schedule index except 1, 2, 9 and 16
  function automatic logic sh_two(input logic [4:0] idx);
    return !((idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16));
  endfunction

  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] v,
                                             input logic left,
                                             input logic two);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = v[HALF_W-1:0];
    d = v[CD_W-1:HALF_W];
    if (left) begin
      c = rotl(c, two);
      d = rotl(d, two);
    end else begin
      c = rotr(c, two);
      d = rotr(d, two);
    end
    return {d, c};
  endfunction

  // PC-2 is pure wiring off the CD register
  for (genvar j = 0; j < RK_W; j++) begin : g_pc2
    assign rkey[j] = cd[PC2_TAB[j] - 1];
  end

  assign rkey_valid = busy;
  assign last_key   = mode_dec ? (round == 4'd0) : (round == 4'(ROUNDS - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cd       <= '0;
      round    <= '0;
      mode_dec <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cd       <= cd_nxt;
      round    <= round_nxt;
      mode_dec <= mode_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    cd_nxt    = cd;
    round_nxt = round;
    mode_nxt  = mode_dec;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_nxt  = decrypt;
          state_nxt = RUN;
          if (decrypt) begin
            cd_nxt    = pc1_key;
            round_nxt = 4'(ROUNDS - 1);
          end else begin
            cd_nxt    = rot_cd(pc1_key, 1'b1, 1'b0);
            round_nxt = 4'd0;
          end
        end
      end
      RUN: begin
        if (rkey_ready) begin
          if (last_key) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (mode_dec) begin
            round_nxt = round - 4'd1;
            cd_nxt    = rot_cd(cd, 1'b0, sh_two(5'(round) + 5'd1));
          end else begin
            round_nxt = round + 4'd1;
            cd_nxt    = rot_cd(cd, 1'b1, sh_two(5'(round) + 5'd2));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == RUN);
  end

endmodule

// File: doc/des_key_schedule.md
Name:
des_key_schedule

Overview:
- Round-key generator stage directly downstream of PC-1 (perm1).
- Latches the 56-bit PC-1 output, splits it into C (bits 27:0) and D (bits 55:28), and rotates C/D per the DES shift schedule.
- Applies PC-2 and streams the sixteen 48-bit round keys to the round-function datapath over a valid/ready handshake.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

Parameters:
- ROUNDS, 16, number of round keys emitted per start; fixed by DES and not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a schedule; sampled only in IDLE
- decrypt  in  1  sampled with start; 1 = emit K16 first
- pc1_key  in  56  perm1 subkey output; bit i = PC-1 output position i+1
- rkey_ready  in  1  consumer accepts rkey this cycle
- rkey_valid  out  1  rkey/round valid
- rkey  out  48  round key; bit j = PC-2 output position j+1
- round  out  4  index of the key on rkey, 0..15 = K1..K16
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final key handshake

Behaviour:
- Bit convention: index 0 = DES position 1. The DES left rotate by s is C'[i] = C[(i+s) mod 28], and the same for D. The right rotate is C'[i] = C[(i-s) mod 28].
- PC-2 maps rkey[j] = CD[p-1], where CD = {D,C}, CD[27:0] = C and CD[55:28] = D. The p sequence for j = 0..47 is: 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
- Shift schedule SH[1..16] = 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1. The total is 28, so C16D16 = C0D0.
- FSM states: IDLE, RUN.
- Reset: state = IDLE; CD, rkey_valid, round, busy and done all 0; rkey = PC2(0) = 0. Reset overrides everything, including mid-schedule, with no further output.
- IDLE with start=1:
  - Latch decrypt into mode_dec.
  - Encrypt: CD <= rotl(pc1_key, SH[1]). Decrypt: CD <= pc1_key, which gives K16.
  - round <= 0 for encrypt, 15 for decrypt.
  - Next state RUN; rkey_valid = 1 from the next cycle. Latency from the start edge to the first valid key is one cycle.
- RUN:
  - rkey is combinational PC2(CD). It is stable while rkey_valid && !rkey_ready.
  - On handshake (rkey_valid && rkey_ready) when not on the last key:
    - Encrypt: round+1, CD <= rotl(CD, SH[round+2]) (1-based table index).
    - Decrypt: round-1, CD <= rotr(CD, SH[round+1]); for example, K16→K15 uses SH[16] = 1.
  - A handshake on the 16th key returns to IDLE: rkey_valid = 0, busy = 0, done = 1 for exactly one cycle.
- With ready held high the block delivers one key per cycle, so 16 cycles for a full schedule.
- start is ignored in RUN, including in the final-handshake cycle. start in the done cycle (now IDLE) is accepted, so back-to-back schedules have a one-cycle gap.
- pc1_key and decrypt are ignored except when start is accepted in IDLE.
- busy = (state == RUN). rkey_valid = busy.

Test Plan:
- Encrypt, FIPS example: drive pc1_key whose bit-reversed value is 0xF0CCAAF556678F (K+), start=1, ready=1.
  - Bit-reversed rkey must be 0x1B02EFFC7072 at round 0 and 0x79AED9DBC9E5 at round 1.
  - The 16th key (round 15) must be 0xCB3D8B0E17F5.
  - done pulses exactly one cycle after the round-15 handshake.
- Decrypt, same key: the first key is 0xCB3D8B0E17F5 (round 15), the last is 0x1B02EFFC7072 (round 0). The full sequence must be the exact reverse of the encrypt capture.
- Backpressure: ready toggles in a pattern of 3 low, 1 high.
  - rkey and round hold constant while ready is low.
  - Exactly 16 handshakes occur, keys match the encrypt sequence, and busy stays high throughout.
- start pulsed mid-schedule, with a different pc1_key and decrypt=1: it is ignored and the output sequence is unchanged. start in the done cycle begins a new schedule with its first valid key on the following cycle.
- Reset asserted at round 7 with valid high: the next cycle has rkey_valid=0, busy=0, round=0, and no done pulse. A fresh start then produces the correct K1.
- All-zero pc1_key: every rkey is 0. All-ones: every rkey is 0xFFFFFFFFFFFF. In both cases there are 16 handshakes and one done pulse.
